// File: rtl/serdes_pkg.sv
// Shared definitions for the multilane SERDES: FSM state encodings and
// sizing helpers used by the top level and the beat timer.
package serdes_pkg;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

    // Number of serial beats needed to move one parallel word.
    function automatic int unsigned calc_beats(input int unsigned data_width,
                                               input int unsigned lanes);
        return data_width / lanes;
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serdes_beat_timer.sv
// Beat timer: free-running modulo-CLOCK_DIV counter.
// Ports: clk/rst_n (async active-low); i_restart forces the count to 0 on the
// next edge; o_tick_c is high in the last cycle of every beat.
module serdes_beat_timer
    import serdes_pkg::*;
#(
    parameter int unsigned CLOCK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick_c
);
    localparam int unsigned   CW   = cnt_width(CLOCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLOCK_DIV - 1);

    logic [CW-1:0] r_count;

    // Count 0..CLOCK_DIV-1, wrapping; restart realigns the beat boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_restart || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tick_c = (r_count == LAST);

endmodule

// File: rtl/parameterized_multilane_serdes.sv
// Full-duplex multilane SERDES. TX splits a DATA_WIDTH word into BEATS chunks
// of LANES bits, each held CLOCK_DIV cycles, with tx_frame marking beat 0.
// RX samples one chunk per beat starting at rx_frame and reassembles the word.
// Ports: clk, rst_n (async active-low), enable; tx_data/tx_valid/tx_ready
// parallel TX handshake; tx_serial/tx_frame serial out; rx_serial/rx_frame
// serial in; rx_data/rx_valid/rx_ready parallel RX handshake; rx_overrun
// sticky flag for words dropped while the previous one was not accepted.
module parameterized_multilane_serdes
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 1,
    parameter int unsigned CLOCK_DIV  = 4,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [LANES-1:0]      tx_serial,
    output logic                  tx_frame,
    input  logic [LANES-1:0]      rx_serial,
    input  logic                  rx_frame,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun
);
    localparam int unsigned   BEATS     = calc_beats(DATA_WIDTH, LANES);
    localparam int unsigned   BW        = cnt_width(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam bit            SINGLE    = (BEATS == 1);

    // Chunk sent first out of a word / word after that chunk is consumed.
    function automatic logic [LANES-1:0] first_chunk(input logic [DATA_WIDTH-1:0] w);
        if (MSB_FIRST != 0) return w[DATA_WIDTH-1 -: LANES];
        return w[LANES-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        if (MSB_FIRST != 0) return w << LANES;
        return w >> LANES;
    endfunction

    // Append a received chunk so the first beat ends up where TX took it from.
    function automatic logic [DATA_WIDTH-1:0] insert_chunk(input logic [DATA_WIDTH-1:0] base,
                                                           input logic [LANES-1:0]      chunk);
        if (MSB_FIRST != 0) return (base << LANES) | DATA_WIDTH'(chunk);
        return (base >> LANES) | (DATA_WIDTH'(chunk) << (DATA_WIDTH - LANES));
    endfunction

    // ------------------------------------------------------------------ TX
    tx_state_e             r_tx_state, w_tx_state_nxt;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [BW-1:0]         r_tx_beat, w_tx_beat_nxt;
    logic [LANES-1:0]      r_tx_serial, w_tx_serial_nxt;
    logic                  r_tx_frame, w_tx_frame_nxt;
    logic                  w_tx_restart, w_tx_tick, w_tx_last;

    serdes_beat_timer #(.CLOCK_DIV(CLOCK_DIV)) u_tx_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_tx_restart),
        .o_tick_c  (w_tx_tick)
    );

    assign tx_ready  = enable && (r_tx_state == TX_IDLE);
    assign w_tx_last = w_tx_tick && (r_tx_beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_state_nxt;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        if (!enable) begin
            w_tx_state_nxt = TX_IDLE;
        end else begin
            case (r_tx_state)
                TX_IDLE:  if (tx_valid)  w_tx_state_nxt = TX_SHIFT;
                TX_SHIFT: if (w_tx_last) w_tx_state_nxt = TX_IDLE;
                default:                 w_tx_state_nxt = TX_IDLE;
            endcase
        end
    end

    // Next values of the TX datapath; serial outputs are registered.
    always_comb begin
        w_tx_shift_nxt  = r_tx_shift;
        w_tx_beat_nxt   = r_tx_beat;
        w_tx_serial_nxt = r_tx_serial;
        w_tx_frame_nxt  = r_tx_frame;
        w_tx_restart    = 1'b0;
        if (!enable || (r_tx_state != TX_SHIFT)) begin
            w_tx_restart    = 1'b1;
            w_tx_beat_nxt   = '0;
            w_tx_serial_nxt = '0;
            w_tx_frame_nxt  = 1'b0;
            if (enable && tx_valid) begin
                w_tx_serial_nxt = first_chunk(tx_data);
                w_tx_shift_nxt  = advance(tx_data);
                w_tx_frame_nxt  = 1'b1;
            end
        end else if (w_tx_tick) begin
            w_tx_frame_nxt = 1'b0;
            if (w_tx_last) begin
                w_tx_beat_nxt   = '0;
                w_tx_serial_nxt = '0;
            end else begin
                w_tx_beat_nxt   = r_tx_beat + BW'(1);
                w_tx_serial_nxt = first_chunk(r_tx_shift);
                w_tx_shift_nxt  = advance(r_tx_shift);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift  <= '0;
            r_tx_beat   <= '0;
            r_tx_serial <= '0;
            r_tx_frame  <= 1'b0;
        end else begin
            r_tx_shift  <= w_tx_shift_nxt;
            r_tx_beat   <= w_tx_beat_nxt;
            r_tx_serial <= w_tx_serial_nxt;
            r_tx_frame  <= w_tx_frame_nxt;
        end
    end

    assign tx_serial = r_tx_serial;
    assign tx_frame  = r_tx_frame;

    // ------------------------------------------------------------------ RX
    rx_state_e             r_rx_state, w_rx_state_nxt;
    logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
    logic [BW-1:0]         r_rx_beat, w_rx_beat_nxt;
    logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_rx_overrun, w_rx_overrun_nxt;
    logic [DATA_WIDTH-1:0] w_rx_word;
    logic                  w_rx_restart, w_rx_tick, w_rx_sample, w_rx_beat0, w_rx_done;

    serdes_beat_timer #(.CLOCK_DIV(CLOCK_DIV)) u_rx_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_rx_restart),
        .o_tick_c  (w_rx_tick)
    );

    // A frame seen at any sample point (or in IDLE) starts a fresh word.
    assign w_rx_sample = enable && ((r_rx_state == RX_IDLE) ? rx_frame : w_rx_tick);
    assign w_rx_beat0  = w_rx_sample && rx_frame;
    assign w_rx_done   = w_rx_sample && (w_rx_beat0 ? SINGLE : (r_rx_beat == LAST_BEAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        if (!enable || w_rx_done) begin
            w_rx_state_nxt = RX_IDLE;
        end else if (w_rx_beat0) begin
            w_rx_state_nxt = RX_RECV;
        end
    end

    // Next values of the RX datapath and parallel handshake.
    always_comb begin
        w_rx_shift_nxt   = r_rx_shift;
        w_rx_beat_nxt    = r_rx_beat;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = r_rx_valid;
        w_rx_overrun_nxt = r_rx_overrun;
        w_rx_restart     = 1'b0;
        w_rx_word        = insert_chunk(w_rx_beat0 ? '0 : r_rx_shift, rx_serial);
        if (!enable) begin
            w_rx_restart     = 1'b1;
            w_rx_beat_nxt    = '0;
            w_rx_overrun_nxt = 1'b0;
        end else begin
            w_rx_restart = (r_rx_state == RX_IDLE) || w_rx_beat0;
            if (w_rx_sample) begin
                w_rx_shift_nxt = w_rx_word;
                w_rx_beat_nxt  = w_rx_beat0 ? BW'(1) : (r_rx_beat + BW'(1));
            end
            if (w_rx_done) begin
                w_rx_beat_nxt = '0;
                if (!r_rx_valid || rx_ready) begin
                    w_rx_data_nxt  = w_rx_word;
                    w_rx_valid_nxt = 1'b1;
                end else begin
                    w_rx_overrun_nxt = 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                w_rx_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift   <= '0;
            r_rx_beat    <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_shift   <= w_rx_shift_nxt;
            r_rx_beat    <= w_rx_beat_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_overrun <= w_rx_overrun_nxt;
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_parameterized_multilane_serdes.sv
// Bench for parameterized_multilane_serdes: an 8-bit serial loopback (with a
// frame/data injection path) and two 16-bit 4-lane loopbacks (MSB/LSB first).
module tb_parameterized_multilane_serdes;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    // ---------------- DUT A: 8 bits, 1 lane, CLOCK_DIV=4, MSB first
    logic       a_enable, a_tx_valid, a_tx_ready, a_tx_frame;
    logic [7:0] a_tx_data, a_rx_data;
    logic [0:0] a_tx_serial, a_rx_serial, a_inj_serial;
    logic       a_rx_frame, a_rx_valid, a_rx_ready, a_rx_overrun;
    logic       a_inj, a_inj_frame;

    assign a_rx_serial = a_inj ? a_inj_serial : a_tx_serial;
    assign a_rx_frame  = a_inj ? a_inj_frame  : a_tx_frame;

    parameterized_multilane_serdes #(
        .DATA_WIDTH(8), .LANES(1), .CLOCK_DIV(4), .MSB_FIRST(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .enable(a_enable),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx_serial(a_tx_serial), .tx_frame(a_tx_frame),
        .rx_serial(a_rx_serial), .rx_frame(a_rx_frame),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
        .rx_overrun(a_rx_overrun)
    );

    // ---------------- DUTs B/C: 16 bits, 4 lanes, CLOCK_DIV=1, MSB / LSB first
    logic        bc_enable, bc_rx_ready, b_tx_valid;
    logic [15:0] b_tx_data;
    logic        b_tx_ready, b_tx_frame, b_rx_valid, b_rx_overrun;
    logic        c_tx_ready, c_tx_frame, c_rx_valid, c_rx_overrun;
    logic [3:0]  b_tx_serial, c_tx_serial;
    logic [15:0] b_rx_data, c_rx_data;

    parameterized_multilane_serdes #(
        .DATA_WIDTH(16), .LANES(4), .CLOCK_DIV(1), .MSB_FIRST(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .enable(bc_enable),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx_serial(b_tx_serial), .tx_frame(b_tx_frame),
        .rx_serial(b_tx_serial), .rx_frame(b_tx_frame),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(bc_rx_ready),
        .rx_overrun(b_rx_overrun)
    );

    parameterized_multilane_serdes #(
        .DATA_WIDTH(16), .LANES(4), .CLOCK_DIV(1), .MSB_FIRST(0)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .enable(bc_enable),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(c_tx_ready),
        .tx_serial(c_tx_serial), .tx_frame(c_tx_frame),
        .rx_serial(c_tx_serial), .rx_frame(c_tx_frame),
        .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(bc_rx_ready),
        .rx_overrun(c_rx_overrun)
    );

    // Count delivered words on DUT A and remember the latest one.
    int         a_valid_cnt = 0;
    logic [7:0] a_last_rx   = '0;
    always @(negedge clk) begin
        if (a_rx_valid) begin
            a_valid_cnt <= a_valid_cnt + 1;
            a_last_rx   <= a_rx_data;
        end
    end

    typedef struct {
        logic [15:0] data;
        logic [15:0] exp_msb;   // beats of u_b, beat 0 in [15:12]
        logic [15:0] exp_lsb;   // beats of u_c, beat 0 in [15:12]
    } vec_t;
    vec_t vecs[4];

    logic [15:0] cap_b, cap_c;
    logic [7:0]  word;
    int          snap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic send_a(input logic [7:0] d);
        int n = 0;
        while (!a_tx_ready && n < 100) begin
            tick();
            n++;
        end
        if (!a_tx_ready) begin
            n_total++;
            $display("FAIL send_wait: tx_ready got 0 expected 1 after %0d cycles", n);
        end
        a_tx_data  = d;
        a_tx_valid = 1'b1;
        tick();
        a_tx_valid = 1'b0;
    endtask

    task automatic inj_beat(input logic f, input logic b);
        a_inj_frame     = f;
        a_inj_serial[0] = b;
        repeat (4) tick();
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h1234, 16'h4321};
        vecs[1] = '{16'hABCD, 16'hABCD, 16'hDCBA};
        vecs[2] = '{16'hF00F, 16'hF00F, 16'hF00F};
        vecs[3] = '{16'h0001, 16'h0001, 16'h1000};

        rst_n        = 1'b0;
        a_enable     = 1'b1;
        a_tx_data    = '0;
        a_tx_valid   = 1'b0;
        a_rx_ready   = 1'b1;
        a_inj        = 1'b0;
        a_inj_frame  = 1'b0;
        a_inj_serial = '0;
        bc_enable    = 1'b1;
        bc_rx_ready  = 1'b1;
        b_tx_valid   = 1'b0;
        b_tx_data    = '0;

        // Reset values
        tick();
        chk("rst_tx_serial", 32'(a_tx_serial), 32'd0);
        chk("rst_tx_frame",  32'(a_tx_frame),  32'd0);
        chk("rst_rx_data",   32'(a_rx_data),   32'd0);
        chk("rst_rx_valid",  32'(a_rx_valid),  32'd0);
        chk("rst_overrun",   32'(a_rx_overrun), 32'd0);
        chk("rst_tx_ready",  32'(a_tx_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // Table: 16-bit 4-lane loopbacks, one word every BEATS+1 cycles
        for (int v = 0; v < 4; v++) begin
            b_tx_data  = vecs[v].data;
            b_tx_valid = 1'b1;
            chk("b_tx_ready", 32'(b_tx_ready), 32'd1);
            chk("c_tx_ready", 32'(c_tx_ready), 32'd1);
            cap_b = '0;
            cap_c = '0;
            for (int c = 1; c <= 5; c++) begin
                tick();
                if (c == 1) begin
                    b_tx_valid = 1'b0;
                    chk("b_frame_beat0", 32'(b_tx_frame), 32'd1);
                end
                if (c == 2) chk("c_frame_beat1", 32'(c_tx_frame), 32'd0);
                if (c <= 4) begin
                    cap_b = {cap_b[11:0], b_tx_serial};
                    cap_c = {cap_c[11:0], c_tx_serial};
                end
                if (c == 4) chk("b_valid_early", 32'(b_rx_valid), 32'd0);
                if (c == 5) begin
                    chk("b_rx_valid", 32'(b_rx_valid), 32'd1);
                    chk("b_rx_data",  32'(b_rx_data),  32'(vecs[v].data));
                    chk("c_rx_valid", 32'(c_rx_valid), 32'd1);
                    chk("c_rx_data",  32'(c_rx_data),  32'(vecs[v].data));
                end
            end
            chk("b_beats_msb", 32'(cap_b), 32'(vecs[v].exp_msb));
            chk("c_beats_lsb", 32'(cap_c), 32'(vecs[v].exp_lsb));
        end
        chk("b_overrun", 32'(b_rx_overrun), 32'd0);
        chk("c_overrun", 32'(c_rx_overrun), 32'd0);

        // 0xA5 loopback: beats MSB first, rx_valid exactly at t+30
        word       = 8'hA5;
        a_tx_data  = word;
        a_tx_valid = 1'b1;
        chk("a_ready_idle", 32'(a_tx_ready), 32'd1);
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 1) begin
                a_tx_valid = 1'b0;
                chk("a_frame_beat0", 32'(a_tx_frame), 32'd1);
            end
            if (c == 5) chk("a_frame_beat1", 32'(a_tx_frame), 32'd0);
            if (((c - 1) % 4 == 0) && (c <= 29))
                chk("a_beat_bit", 32'(a_tx_serial), 32'(word[7 - (c - 1) / 4]));
            if (c == 29) chk("a_valid_t29", 32'(a_rx_valid), 32'd0);
            if (c == 30) begin
                chk("a_valid_t30", 32'(a_rx_valid), 32'd1);
                chk("a_data_t30",  32'(a_rx_data),  32'hA5);
            end
            if (c == 31) chk("a_valid_cleared", 32'(a_rx_valid), 32'd0);
            if (c == 32) chk("a_ready_busy", 32'(a_tx_ready), 32'd0);
            if (c == 33) begin
                chk("a_ready_back", 32'(a_tx_ready), 32'd1);
                chk("a_serial_idle", 32'(a_tx_serial), 32'd0);
            end
        end

        // Overrun: second word dropped while the first is unaccepted
        a_rx_ready = 1'b0;
        send_a(8'h11);
        send_a(8'h22);
        chk("ovr_first_valid", 32'(a_rx_valid),   32'd1);
        chk("ovr_first_data",  32'(a_rx_data),    32'h11);
        chk("ovr_not_yet",     32'(a_rx_overrun), 32'd0);
        repeat (35) tick();
        chk("ovr_data_kept", 32'(a_rx_data),    32'h11);
        chk("ovr_valid",     32'(a_rx_valid),   32'd1);
        chk("ovr_flag",      32'(a_rx_overrun), 32'd1);
        a_rx_ready = 1'b1;
        tick();
        chk("ovr_valid_clr", 32'(a_rx_valid),   32'd0);
        chk("ovr_sticky",    32'(a_rx_overrun), 32'd1);

        // Resync: frame at beat 3 of a partial word, then a clean 0x3C
        snap  = a_valid_cnt;
        a_inj = 1'b1;
        inj_beat(1'b1, 1'b1);
        inj_beat(1'b0, 1'b1);
        inj_beat(1'b0, 1'b1);
        word = 8'h3C;
        for (int k = 0; k < 8; k++) inj_beat(k == 0, word[7 - k]);
        a_inj       = 1'b0;
        a_inj_frame = 1'b0;
        repeat (4) tick();
        chk("resync_count", 32'(a_valid_cnt - snap), 32'd1);
        chk("resync_data",  32'(a_last_rx),          32'h3C);

        // Enable drop at beat 4 of 0xFF, then 0x5A
        snap = a_valid_cnt;
        send_a(8'hFF);
        repeat (16) tick();
        chk("en_beat4_bit", 32'(a_tx_serial),  32'd1);
        chk("en_ovr_before", 32'(a_rx_overrun), 32'd1);
        a_enable = 1'b0;
        tick();
        chk("en_serial_0",  32'(a_tx_serial),  32'd0);
        chk("en_frame_0",   32'(a_tx_frame),   32'd0);
        chk("en_ready_0",   32'(a_tx_ready),   32'd0);
        chk("en_ovr_clr",   32'(a_rx_overrun), 32'd0);
        chk("en_data_hold", 32'(a_rx_data),    32'h3C);
        repeat (3) tick();
        a_enable = 1'b1;
        repeat (40) tick();
        chk("en_no_valid", 32'(a_valid_cnt - snap), 32'd0);
        send_a(8'h5A);
        repeat (35) tick();
        chk("en_next_count", 32'(a_valid_cnt - snap), 32'd1);
        chk("en_next_data",  32'(a_last_rx),          32'h5A);

        // Asynchronous reset mid-word, then 0x96
        send_a(8'hC3);
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_serial",  32'(a_tx_serial),  32'd0);
        chk("mrst_rx_data", 32'(a_rx_data),    32'd0);
        chk("mrst_valid",   32'(a_rx_valid),   32'd0);
        chk("mrst_ready",   32'(a_tx_ready),   32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        snap  = a_valid_cnt;
        send_a(8'h96);
        repeat (35) tick();
        chk("mrst_next_count", 32'(a_valid_cnt - snap), 32'd1);
        chk("mrst_next_data",  32'(a_last_rx),          32'h96);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
